// File: rtl/pipe_pkg.sv
// Shared types and default widths for the writeback pipeline stage.
package pipe_pkg;

    localparam int DEFAULT_DATA_BIT_WIDTH = 32;
    localparam int DEFAULT_REG_NO_WIDTH   = 4;

    typedef struct packed {
        logic [DEFAULT_DATA_BIT_WIDTH-1:0] data;
        logic [DEFAULT_REG_NO_WIDTH-1:0]   regNo;
        logic                              wrReg;
    } wb_entry_t;

    // Slot index of the entry 'offset' places younger than 'base' in a ring of 'depth'.
    function automatic int wrap_slot(input int base, input int offset, input int depth);
        return (base + offset) % depth;
    endfunction

endpackage

// File: rtl/pipe_wb_fwd_mux.sv
// Youngest-match forwarding select over the valid entries of the writeback ring.
module pipe_wb_fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = DEFAULT_DATA_BIT_WIDTH,
    parameter int REG_NO_WIDTH   = DEFAULT_REG_NO_WIDTH,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE = '0,
    parameter int DEPTH          = 2,
    parameter int PTR_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][DATA_BIT_WIDTH-1:0] data,
    input  logic [DEPTH-1:0][REG_NO_WIDTH-1:0]   reg_no,
    input  logic [DEPTH-1:0]                     wr_reg,
    input  logic [PTR_W-1:0]                     rd_ptr,
    input  logic [CNT_W-1:0]                     count,
    input  logic [REG_NO_WIDTH-1:0]              query,
    output logic                                 hit,
    output logic [DATA_BIT_WIDTH-1:0]            hit_data
);

    // Walk from oldest to youngest so the last match seen wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = RESET_VALUE;
        for (int age = 0; age < DEPTH; age++) begin
            if (age < int'(count)
                && wr_reg[PTR_W'(wrap_slot(int'(rd_ptr), age, DEPTH))]
                && reg_no[PTR_W'(wrap_slot(int'(rd_ptr), age, DEPTH))] == query) begin
                hit      = 1'b1;
                hit_data = data[PTR_W'(wrap_slot(int'(rd_ptr), age, DEPTH))];
            end
        end
    end

endmodule

// File: rtl/pipe_wb_stage.sv
// Writeback buffer stage: DEPTH-entry in-order FIFO of {data, regNo, wrReg}.
// Optional forwarding lookup enabled by the PIPE_WB_STAGE_FWD_EN macro.
module pipe_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = DEFAULT_DATA_BIT_WIDTH,
    parameter int REG_NO_WIDTH   = DEFAULT_REG_NO_WIDTH,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE = '0,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [DATA_BIT_WIDTH-1:0] wrRegDataIn,
    input  logic [REG_NO_WIDTH-1:0]   regWriteNoIn,
    input  logic                      wrRegIn,
    input  logic                      flush,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [DATA_BIT_WIDTH-1:0] wrRegDataOut,
    output logic [REG_NO_WIDTH-1:0]   regWriteNoOut,
    output logic                      wrRegOut,
    input  logic [REG_NO_WIDTH-1:0]   fwdRegNo,
    output logic                      fwdHit,
    output logic [DATA_BIT_WIDTH-1:0] fwdData
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_BIT_WIDTH-1:0] data_q;
    logic [DEPTH-1:0][REG_NO_WIDTH-1:0]   reg_no_q;
    logic [DEPTH-1:0]                     wr_reg_q;
    logic [PTR_W-1:0]                     rd_ptr;
    logic [PTR_W-1:0]                     wr_ptr;
    logic [CNT_W-1:0]                     count;
    logic                                 push;
    logic                                 pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on registered count, so no path from outReady.
    assign inReady  = (count != FULL_COUNT);
    assign outValid = (count != '0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && reset && !flush) begin
            data_q[wr_ptr]   <= wrRegDataIn;
            reg_no_q[wr_ptr] <= regWriteNoIn;
            wr_reg_q[wr_ptr] <= wrRegIn;
        end
    end

    assign wrRegDataOut  = outValid ? data_q[rd_ptr]   : RESET_VALUE;
    assign regWriteNoOut = outValid ? reg_no_q[rd_ptr] : '0;
    assign wrRegOut      = outValid ? wr_reg_q[rd_ptr] : 1'b0;

`ifdef PIPE_WB_STAGE_FWD_EN
    pipe_wb_fwd_mux #(
        .DATA_BIT_WIDTH(DATA_BIT_WIDTH),
        .REG_NO_WIDTH  (REG_NO_WIDTH),
        .RESET_VALUE   (RESET_VALUE),
        .DEPTH         (DEPTH),
        .PTR_W         (PTR_W),
        .CNT_W         (CNT_W)
    ) fwd_mux (
        .data    (data_q),
        .reg_no  (reg_no_q),
        .wr_reg  (wr_reg_q),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .query   (fwdRegNo),
        .hit     (fwdHit),
        .hit_data(fwdData)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^fwdRegNo;
    assign fwdHit     = 1'b0;
    assign fwdData    = RESET_VALUE;
`endif

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Self-checking bench for pipe_wb_stage against a queue-based reference model.
module tb_pipe_wb_stage;
    import pipe_pkg::*;

    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int DEPTH = 2;

`ifdef PIPE_WB_STAGE_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] wrRegDataIn;
    logic [RW-1:0] regWriteNoIn;
    logic          wrRegIn;
    logic          flush;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] wrRegDataOut;
    logic [RW-1:0] regWriteNoOut;
    logic          wrRegOut;
    logic [RW-1:0] fwdRegNo;
    logic          fwdHit;
    logic [DW-1:0] fwdData;

    wb_entry_t modelQ[$];
    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    pipe_wb_stage #(
        .DATA_BIT_WIDTH(DW),
        .REG_NO_WIDTH  (RW),
        .RESET_VALUE   ('0),
        .DEPTH         (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inValid      (inValid),
        .inReady      (inReady),
        .wrRegDataIn  (wrRegDataIn),
        .regWriteNoIn (regWriteNoIn),
        .wrRegIn      (wrRegIn),
        .flush        (flush),
        .outValid     (outValid),
        .outReady     (outReady),
        .wrRegDataOut (wrRegDataOut),
        .regWriteNoOut(regWriteNoOut),
        .wrRegOut     (wrRegOut),
        .fwdRegNo     (fwdRegNo),
        .fwdHit       (fwdHit),
        .fwdData      (fwdData)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs come from the model queue: head is index 0, youngest is last.
    task automatic checkOutput(input string tag);
        logic          expHit;
        logic [DW-1:0] expFwd;
        wb_entry_t     head;
        expHit = 1'b0;
        expFwd = '0;
        head   = '0;
        if (modelQ.size() != 0) head = modelQ[0];
        if (FWD_ON) begin
            foreach (modelQ[i]) begin
                if (modelQ[i].wrReg && modelQ[i].regNo == fwdRegNo) begin
                    expHit = 1'b1;
                    expFwd = modelQ[i].data;
                end
            end
        end
        checkValue({tag, ".outValid"}, 32'(outValid), 32'(modelQ.size() != 0));
        checkValue({tag, ".inReady"}, 32'(inReady), 32'(modelQ.size() != DEPTH));
        checkValue({tag, ".data"}, wrRegDataOut, head.data);
        checkValue({tag, ".regNo"}, 32'(regWriteNoOut), 32'(head.regNo));
        checkValue({tag, ".wrReg"}, 32'(wrRegOut), 32'(head.wrReg));
        checkValue({tag, ".fwdHit"}, 32'(fwdHit), 32'(expHit));
        checkValue({tag, ".fwdData"}, fwdData, expFwd);
    endtask

    task automatic applyStimulus(input logic rstN, input logic inV, input logic [DW-1:0] d,
                                 input logic [RW-1:0] rn, input logic wr, input logic fl,
                                 input logic oRdy, input logic [RW-1:0] fq, input string tag);
        bit        doPush;
        bit        doPop;
        wb_entry_t entry;
        @(negedge clk);
        reset        = rstN;
        inValid      = inV;
        wrRegDataIn  = d;
        regWriteNoIn = rn;
        wrRegIn      = wr;
        flush        = fl;
        outReady     = oRdy;
        fwdRegNo     = fq;
        #1 checkOutput({tag, ".pre"});
        doPop  = (modelQ.size() != 0) && oRdy;
        doPush = inV && (modelQ.size() < DEPTH);
        entry.data  = d;
        entry.regNo = rn;
        entry.wrReg = wr;
        @(posedge clk);
        if (!rstN || fl) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(entry);
        end
        #1 checkOutput({tag, ".post"});
    endtask

    initial begin
        reset        = 1'b0;
        inValid      = 1'b0;
        wrRegDataIn  = '0;
        regWriteNoIn = '0;
        wrRegIn      = 1'b0;
        flush        = 1'b0;
        outReady     = 1'b0;
        fwdRegNo     = '0;
        repeat (2) @(posedge clk);
        #1 checkOutput("reset");

        applyStimulus(1'b1, 1'b1, 32'hA5, 4'd3, 1'b1, 1'b0, 1'b0, 4'd3, "push1");
        applyStimulus(1'b1, 1'b1, 32'h5A, 4'd4, 1'b1, 1'b0, 1'b0, 4'd3, "push2");
        checkValue("full.inReady", 32'(inReady), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'hEE, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, "push3Blocked");
        checkValue("full.head", wrRegDataOut, 32'hA5);
        checkValue("full.regNo", 32'(regWriteNoOut), 32'd3);

        applyStimulus(1'b1, 1'b1, 32'hEE, 4'd7, 1'b1, 1'b0, 1'b1, 4'd0, "pop1");
        checkValue("pop1.head", wrRegDataOut, 32'h5A);
        applyStimulus(1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, "pop2");
        checkValue("pop2.outValid", 32'(outValid), 32'd0);

        applyStimulus(1'b1, 1'b1, 32'h77, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, "one");
        applyStimulus(1'b1, 1'b1, 32'h11, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, "pushPop");
        checkValue("pushPop.head", wrRegDataOut, 32'h11);
        checkValue("pushPop.inReady", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, "drain");

        applyStimulus(1'b1, 1'b1, 32'h10, 4'd3, 1'b1, 1'b0, 1'b0, 4'd3, "fwdOld");
        applyStimulus(1'b1, 1'b1, 32'h20, 4'd3, 1'b1, 1'b0, 1'b0, 4'd3, "fwdYoung");
        applyStimulus(1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, "fwdIdle");
        checkValue("fwd.hit", 32'(fwdHit), 32'(FWD_ON));
        checkValue("fwd.data", fwdData, FWD_ON ? 32'h20 : 32'h0);

        applyStimulus(1'b1, 1'b1, 32'hBB, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, "flush");
        checkValue("flush.outValid", 32'(outValid), 32'd0);
        checkValue("flush.inReady", 32'(inReady), 32'd1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 2) != 0),
                          32'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
